// File: rtl/morra_player_driver_if.sv
// Move-script stream between a script source and morra_player_driver.
// The master presents {mv_primo, mv_secondo} under mv_valid; the slave accepts while mv_ready is high.
interface morra_player_driver_if;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_primo;
  logic [1:0] mv_secondo;

  modport master (output mv_valid, output mv_primo, output mv_secondo, input mv_ready);
  modport slave  (input mv_valid, input mv_primo, input mv_secondo, output mv_ready);
endinterface

// File: rtl/morra_player_driver.sv
// Match sequencer for the Morra Cinese game: buffers scripted moves, runs a match, tallies rounds.
// Optional MORRA_LEGAL_FILTER_EN: drop head entries that the game would reject, without spending a game cycle.
module morra_player_driver #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_MOVES = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           extra_rounds,
  morra_player_driver_if.slave mv,
  output logic [1:0]           Primo,
  output logic [1:0]           Secondo,
  output logic                 Inizia,
  input  logic [1:0]           Manche,
  input  logic [1:0]           Partita,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic                 timeout,
  output logic [4:0]           wins_p,
  output logic [4:0]           wins_s,
  output logic [4:0]           ties,
  output logic [4:0]           rejected
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [4:0]  MAX5 = 5'(MAX_MOVES);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLAY, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, drop, issue;
  logic [1:0]    head_p, head_s;
  logic [4:0]    issued;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == '1) ? v : v + 5'd1;
  endfunction

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign mv.mv_ready = !full;
  assign push        = mv.mv_valid && !full;
  assign pop         = (state == S_PLAY) && !empty;
  assign issue       = pop && !drop;
  assign {head_p, head_s} = mem[rd_ptr];

  // FIFO contents survive match boundaries; only rst flushes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {mv.mv_primo, mv.mv_secondo};
  end

`ifdef MORRA_LEGAL_FILTER_EN
  logic [1:0] vp, vs, last_p, last_s;

  assign drop = (head_p == 2'b00) || (head_s == 2'b00) || (head_p == vp) || (head_s == vs);

  // Advantage moves follow the game's verdict: the round winner's move becomes forbidden to repeat.
  always_ff @(posedge clk) begin
    if (rst || state == S_INIT) begin
      vp     <= '0;
      vs     <= '0;
      last_p <= '0;
      last_s <= '0;
    end else if (issue) begin
      last_p <= head_p;
      last_s <= head_s;
    end else if (state == S_WAIT) begin
      case (Manche)
        2'b01:   begin vp <= last_p; vs <= '0;     end
        2'b10:   begin vp <= '0;     vs <= last_s; end
        2'b11:   begin vp <= '0;     vs <= '0;     end
        default: ;
      endcase
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    Primo    = 2'b00;
    Secondo  = 2'b00;
    Inizia   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_INIT;
      S_INIT: begin
        Inizia   = 1'b1;
        busy     = 1'b1;
        Primo    = extra_rounds[3:2];
        Secondo  = extra_rounds[1:0];
        state_nx = S_PLAY;
      end
      S_PLAY: begin
        busy = 1'b1;
        if (issue) begin
          Primo    = head_p;
          Secondo  = head_s;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        busy     = 1'b1;
        state_nx = (Partita != 2'b00 || issued == MAX5) ? S_DONE : S_PLAY;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      issued   <= '0;
      wins_p   <= '0;
      wins_s   <= '0;
      ties     <= '0;
      rejected <= '0;
      result   <= '0;
      timeout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_INIT: begin
          issued   <= '0;
          wins_p   <= '0;
          wins_s   <= '0;
          ties     <= '0;
          rejected <= '0;
          result   <= '0;
          timeout  <= 1'b0;
        end
        S_PLAY: begin
          if (issue)     issued   <= issued + 5'd1;
          else if (pop)  rejected <= sat_inc(rejected);
        end
        S_WAIT: begin
          case (Manche)
            2'b00:   rejected <= sat_inc(rejected);
            2'b01:   wins_p   <= sat_inc(wins_p);
            2'b10:   wins_s   <= sat_inc(wins_s);
            default: ties     <= sat_inc(ties);
          endcase
          if (Partita != 2'b00) begin
            result <= Partita;
          end else if (issued == MAX5) begin
            timeout <= 1'b1;
            result  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_player_driver.sv
// Bench for morra_player_driver: behavioural game model, scripted/random move source, match-level reference.
module tb_morra_player_driver;

  localparam int DEPTH     = 8;
  localparam int MAX_MOVES = 31;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] extra_rounds = '0;
  logic [1:0] Primo, Secondo, Manche, Partita, result;
  logic       Inizia, busy, done, timeout;
  logic [4:0] wins_p, wins_s, ties, rejected;

  morra_player_driver_if mvif ();

  morra_player_driver #(.DEPTH(DEPTH), .MAX_MOVES(MAX_MOVES)) dut (
    .clk(clk), .rst(rst), .start(start), .extra_rounds(extra_rounds), .mv(mvif),
    .Primo(Primo), .Secondo(Secondo), .Inizia(Inizia), .Manche(Manche), .Partita(Partita),
    .busy(busy), .done(done), .result(result), .timeout(timeout),
    .wins_p(wins_p), .wins_s(wins_s), .ties(ties), .rejected(rejected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] result;
    logic       timeout;
    logic [4:0] wp, ws, t, rj;
  } exp_t;

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0;
  int cur_extra = 0;
  bit rand_en = 1'b0, push_hold = 1'b0;
  logic [3:0] script [$];
  logic [3:0] fifo_m [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10);
  endfunction

  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] s,
                                       input logic [1:0] vp, input logic [1:0] vs);
    if (p == 2'b00 || s == 2'b00 || p == vp || s == vs) return 2'b00;
    if (p == s) return 2'b11;
    return beats(p, s) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] final_res(input int wp, input int ws);
    if (wp > ws) return 2'b01;
    if (ws > wp) return 2'b10;
    return 2'b11;
  endfunction

  // Game: a decisive round may not be won twice in a row with the same move; the match is
  // decided after 4+extra decisive rounds (ties and illegal rounds do not count).
  logic [1:0] g_vp, g_vs;
  logic [3:0] g_extra;
  int         g_dec, g_wp, g_ws;
  logic [1:0] g_m;
  assign g_m = judge(Primo, Secondo, g_vp, g_vs);

  always @(posedge clk) begin
    if (rst || Inizia) begin
      Manche  <= 2'b00;
      Partita <= 2'b00;
      g_vp    <= 2'b00;
      g_vs    <= 2'b00;
      g_dec   <= 0;
      g_wp    <= 0;
      g_ws    <= 0;
      g_extra <= rst ? 4'd0 : {Primo, Secondo};
    end else if ((Primo != 2'b00 || Secondo != 2'b00) && Partita == 2'b00) begin
      Manche <= g_m;
      if (g_m == 2'b01) begin g_vp <= Primo; g_vs <= 2'b00; g_wp <= g_wp + 1; end
      if (g_m == 2'b10) begin g_vp <= 2'b00; g_vs <= Secondo; g_ws <= g_ws + 1; end
      if (g_m == 2'b11) begin g_vp <= 2'b00; g_vs <= 2'b00; end
      if (g_m == 2'b01 || g_m == 2'b10) begin
        g_dec <= g_dec + 1;
        if (g_dec + 1 == 4 + int'(g_extra))
          Partita <= final_res(g_wp + int'(g_m == 2'b01), g_ws + int'(g_m == 2'b10));
      end
    end else begin
      Manche <= 2'b00;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic [3:0] rand_move();
    logic [1:0] f [2];
    for (int i = 0; i < 2; i++) begin
      int r = $urandom_range(9);
      f[i] = (r == 0) ? 2'b00 : 2'(1 + (r % 3));
    end
    return {f[0], f[1]};
  endfunction

  // Move source: offers an entry only while mv_ready, so every offered entry is accepted.
  initial begin
    logic [3:0] m;
    mvif.mv_valid   = 1'b0;
    mvif.mv_primo   = 2'b00;
    mvif.mv_secondo = 2'b00;
    forever begin
      @(negedge clk);
      if (!push_hold) begin
        if (!rst && mvif.mv_ready &&
            (script.size() > 0 || (rand_en && $urandom_range(3) != 0))) begin
          m = (script.size() > 0) ? script.pop_front() : rand_move();
          {mvif.mv_primo, mvif.mv_secondo} = m;
          mvif.mv_valid = 1'b1;
          fifo_m.push_back(m);
        end else begin
          mvif.mv_valid = 1'b0;
        end
      end
    end
  end

  // Whole-match reference: walk the accepted script in order applying the game rules.
  task automatic ref_match(input int extra, output exp_t e);
    logic [1:0] vp = 2'b00, vs = 2'b00, p, s, m;
    int dec = 0, issued = 0, wp = 0, ws = 0, t = 0, rj = 0;
    e = '0;
    while (fifo_m.size() > 0) begin
      {p, s} = fifo_m.pop_front();
      m = judge(p, s, vp, vs);
`ifdef MORRA_LEGAL_FILTER_EN
      if (m == 2'b00) begin rj++; continue; end
`endif
      issued++;
      case (m)
        2'b00: rj++;
        2'b01: begin wp++; vp = p; vs = 2'b00; dec++; end
        2'b10: begin ws++; vs = s; vp = 2'b00; dec++; end
        default: begin t++; vp = 2'b00; vs = 2'b00; end
      endcase
      if ((m == 2'b01 || m == 2'b10) && dec == 4 + extra) begin
        e.result = final_res(wp, ws);
        break;
      end
      if (issued == MAX_MOVES) begin
        e.timeout = 1'b1;
        break;
      end
    end
    e.wp = 5'((wp > 31) ? 31 : wp);
    e.ws = 5'((ws > 31) ? 31 : ws);
    e.t  = 5'((t  > 31) ? 31 : t);
    e.rj = 5'((rj > 31) ? 31 : rj);
  endtask

  task automatic start_match(input int extra, input string tag);
    @(negedge clk);
    extra_rounds = 4'(extra);
    cur_extra    = extra;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_inizia"}, 32'(Inizia), 1);
    check({tag, "_init_primo"}, 32'(Primo), 32'(extra_rounds[3:2]));
    check({tag, "_init_secondo"}, 32'(Secondo), 32'(extra_rounds[1:0]));
  endtask

  task automatic finish_match(input string tag);
    exp_t e;
    int d0 = done_cnt;
    int cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    rand_en = 1'b0;
    ref_match(cur_extra, e);
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    check({tag, "_done_low"}, 32'(done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_result"}, 32'(result), 32'(e.result));
    check({tag, "_timeout"}, 32'(timeout), 32'(e.timeout));
    check({tag, "_wins_p"}, 32'(wins_p), 32'(e.wp));
    check({tag, "_wins_s"}, 32'(wins_s), 32'(e.ws));
    check({tag, "_ties"}, 32'(ties), 32'(e.t));
    check({tag, "_rejected"}, 32'(rejected), 32'(e.rj));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc, d0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(mvif.mv_ready), 1);
    check("rst_inizia", 32'(Inizia), 0);
    check("rst_moves", 32'({Primo, Secondo}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_counters", 32'({wins_p, wins_s, ties, rejected, result, timeout}), 0);

    // Four legal first-player wins.
    script = '{4'b1001, 4'b0111, 4'b1110, 4'b1001};
    start_match(0, "t2");
    finish_match("t2");
    check("t2_wins_p_const", 32'(wins_p), 4);
    check("t2_result_const", 32'(result), 1);
    check("t2_timeout_const", 32'(timeout), 0);

    // Winner repeats its move on round 2.
    script = '{4'b1001, 4'b1001, 4'b0111, 4'b1110, 4'b1001};
    start_match(0, "t3");
    finish_match("t3");
    check("t3_rejected_const", 32'(rejected), 1);
    check("t3_wins_p_const", 32'(wins_p), 4);

    // start while busy is ignored.
    start_match(0, "t6");
    script = '{4'b1001, 4'b0111};
    cyc = 0;
    while (wins_p != 5'd2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("t6_reached_two", 32'(wins_p), 2);
    extra_rounds = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra_rounds = 4'h0;
    check("t6_no_inizia", 32'(Inizia), 0);
    check("t6_busy", 32'(busy), 1);
    check("t6_wins_kept", 32'(wins_p), 2);
    script = '{4'b1110, 4'b1001};
    finish_match("t6");
    check("t6_wins_p_const", 32'(wins_p), 4);

    // Watchdog: 31 ties.
    for (int i = 0; i < 31; i++) script.push_back(4'b0101);
    start_match(0, "t4");
    finish_match("t4");
    check("t4_timeout_const", 32'(timeout), 1);
    check("t4_result_const", 32'(result), 0);
    check("t4_ties_const", 32'(ties), 31);

    // Fill the FIFO, offer one more entry, then reset mid-match in WAIT.
    for (int i = 0; i < DEPTH; i++) script.push_back(4'b0101);
    cyc = 0;
    while (script.size() > 0 && cyc < 200) begin @(negedge clk); cyc++; end
    push_hold = 1'b1;
    @(negedge clk);
    check("t5_full_ready", 32'(mvif.mv_ready), 0);
    {mvif.mv_primo, mvif.mv_secondo} = 4'b1001;
    mvif.mv_valid = 1'b1;
    repeat (2) @(negedge clk);
    mvif.mv_valid = 1'b0;
    start_match(0, "t5");
    cyc = 0;
    while (ties != 5'd8 && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (4) @(negedge clk);
    check("t5_ties", 32'(ties), 8);
    check("t5_dropped", 32'(wins_p), 0);
    check("t5_still_busy", 32'(busy), 1);
    check("t5_ready_again", 32'(mvif.mv_ready), 1);
    {mvif.mv_primo, mvif.mv_secondo} = 4'b0101;
    mvif.mv_valid = 1'b1;
    @(negedge clk);
    mvif.mv_valid = 1'b0;
    cyc = 0;
    while (Primo == 2'b00 && cyc < 50) begin @(negedge clk); cyc++; end
    check("t5_move_driven", 32'(Primo), 1);
    @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_counters", 32'({wins_p, wins_s, ties, rejected, result, timeout}), 0);
    check("t5_rst_ready", 32'(mvif.mv_ready), 1);
    @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 0);
    fifo_m.delete();
    push_hold = 1'b0;

    // Randomized matches; leftover entries carry over into the next match.
    for (int k = 0; k < 12; k++) begin
      rand_en = 1'b1;
      start_match(int'($urandom_range(5)), "rnd");
      finish_match("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
